// File: rtl/ysyx22041405_pkg.sv
// Shared constants and helpers for the ysyx22041405 NPC core.
package ysyx22041405_pkg;

    localparam int RV32I_NREG = 32;
    localparam int RV32E_NREG = 16;
    localparam int X0_ADDR    = 0;

    // Fallback for flows whose elaborator lacks $clog2.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/ysyx22041405_regfile_sb_if.sv
// Register-file bus between IDU/WBU (master) and the regfile with scoreboard (slave).
interface ysyx22041405_regfile_sb_if
    import ysyx22041405_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NREG  = RV32I_NREG,
    parameter int NRD   = 2,
    parameter int NWR   = 1,
    parameter int AW    = $clog2(NREG)
);
    logic [NRD*AW-1:0]    raddr;
    logic [NRD*WIDTH-1:0] rdata;
    logic [NRD-1:0]       rready;
    logic [NWR-1:0]       we;
    logic [NWR*AW-1:0]    waddr;
    logic [NWR*WIDTH-1:0] wdata;
    logic                 iss_valid;
    logic [AW-1:0]        iss_rd;
    logic [NREG-1:0]      busy;
    logic [15:0]          wr_cnt;

    modport master (
        output raddr, we, waddr, wdata, iss_valid, iss_rd,
        input  rdata, rready, busy, wr_cnt
    );

    modport slave (
        input  raddr, we, waddr, wdata, iss_valid, iss_rd,
        output rdata, rready, busy, wr_cnt
    );

endinterface

// File: rtl/ysyx22041405_rf_scoreboard.sv
// Per-register busy tracking: issue sets, write-back clears, issue wins a tie.
module ysyx22041405_rf_scoreboard
    import ysyx22041405_pkg::*;
#(
    parameter int NREG = RV32I_NREG,
    parameter int NWR  = 1,
    parameter int AW   = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NWR-1:0]    we,
    input  logic [NWR*AW-1:0] waddr,
    input  logic              iss_valid,
    input  logic [AW-1:0]     iss_rd,
    output logic [NREG-1:0]   busy
);
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_nxt;

    always_comb begin
        busy_nxt = busy_q;
        for (int j = 0; j < NWR; j++)
            if (we[j]) busy_nxt[waddr[j*AW +: AW]] = 1'b0;
        // Applied after the clears so a new producer keeps ownership.
        if (iss_valid) busy_nxt[iss_rd] = 1'b1;
        busy_nxt[X0_ADDR] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_nxt;
    end

    assign busy = busy_q;

endmodule

// File: rtl/ysyx22041405_regfile_sb.sv
// Multi-port integer register file with x0 hardwiring, write-to-read bypass and busy scoreboard.
module ysyx22041405_regfile_sb
    import ysyx22041405_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NREG  = RV32I_NREG,
    parameter int NRD   = 2,
    parameter int NWR   = 1
) (
    input logic                       clk,
    input logic                       rst,
    ysyx22041405_regfile_sb_if.slave  bus
);
    localparam int AW = $clog2(NREG);

    logic [WIDTH-1:0]     rf [NREG];
    logic [NREG-1:0]      busy;
    logic [15:0]          wr_cnt;
    logic                 any_wr;
    logic [NRD*WIDTH-1:0] rdata;
    logic [NRD-1:0]       rready;

    ysyx22041405_rf_scoreboard #(.NREG(NREG), .NWR(NWR), .AW(AW)) u_sb (
        .clk       (clk),
        .rst       (rst),
        .we        (bus.we),
        .waddr     (bus.waddr),
        .iss_valid (bus.iss_valid),
        .iss_rd    (bus.iss_rd),
        .busy      (busy)
    );

    always_comb begin
        any_wr = 1'b0;
        for (int j = 0; j < NWR; j++)
            if (bus.we[j] && bus.waddr[j*AW +: AW] != AW'(X0_ADDR)) any_wr = 1'b1;
    end

    // Later ports are applied last, so the highest index wins a collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) rf[r] <= '0;
            wr_cnt <= '0;
        end else begin
            for (int j = 0; j < NWR; j++)
                if (bus.we[j] && bus.waddr[j*AW +: AW] != AW'(X0_ADDR))
                    rf[bus.waddr[j*AW +: AW]] <= bus.wdata[j*WIDTH +: WIDTH];
            if (any_wr && wr_cnt != 16'hFFFF) wr_cnt <= wr_cnt + 16'd1;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0]    ra;
        logic             hit;
        logic [WIDTH-1:0] byp;
        logic [WIDTH-1:0] rd;
        logic             rdy;

        assign ra = bus.raddr[i*AW +: AW];

        always_comb begin
            hit = 1'b0;
            byp = '0;
            for (int j = 0; j < NWR; j++)
                if (bus.we[j] && bus.waddr[j*AW +: AW] == ra) begin
                    hit = 1'b1;
                    byp = bus.wdata[j*WIDTH +: WIDTH];
                end
        end

        // A same-cycle write satisfies the operand even if the reg is still marked busy.
        always_comb begin
            rd  = '0;
            rdy = 1'b1;
            if (!rst && ra != AW'(X0_ADDR)) begin
                rd  = hit ? byp : rf[ra];
                rdy = hit || !busy[ra];
            end
        end

        assign rdata[i*WIDTH +: WIDTH] = rd;
        assign rready[i]               = rdy;
    end

    assign bus.rdata  = rdata;
    assign bus.rready = rready;
    assign bus.busy   = busy;
    assign bus.wr_cnt = wr_cnt;

endmodule
